// File: rtl/decode_pipe.sv
// MIPS-style ID stage: decode, register file with write-through, load-use hazard
// detection, and the ID/EX pipeline register.
module decode_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned CW   = 16,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  input  logic            instr_valid,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs_data,
  output logic [XLEN-1:0] ex_rt_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [AW-1:0]   ex_rs,
  output logic [AW-1:0]   ex_rt,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_regdst,
  output logic            ex_alusrc,
  output logic            ex_memtoreg,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic [1:0]      ex_aluop,
  output logic            ex_illegal,
  output logic [CW-1:0]   stall_count
);

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rs;
    logic [AW-1:0]   rt;
    logic [AW-1:0]   rd;
    ctrl_t           ctrl;
  } idex_t;

  logic [5:0]      opcode;
  logic [AW-1:0]   rs, rt, rd;
  logic [15:0]     imm16;
  ctrl_t           ctrl;
  logic            rt_src;
  logic            zext;
  logic [XLEN-1:0] rs_data, rt_data;
  logic            bubble;
  logic            unused_funct;

  logic [XLEN-1:0] rf_q [NREG];
  idex_t           idex_q, idex_d;
  logic [CW-1:0]   stall_count_q, stall_count_d;

  assign opcode       = instr_in[31:26];
  assign rs           = AW'(instr_in[25:21]);
  assign rt           = AW'(instr_in[20:16]);
  assign rd           = AW'(instr_in[15:11]);
  assign imm16        = instr_in[15:0];
  assign unused_funct = ^instr_in[10:0];

  always_comb begin
    ctrl   = '0;
    rt_src = 1'b0;
    zext   = 1'b0;
    case (opcode)
      6'b000000: begin ctrl = ctrl_t'({7'b1001000, 2'b10, 1'b0}); rt_src = 1'b1; end
      6'b100011: ctrl = ctrl_t'({7'b0111100, 2'b00, 1'b0});
      6'b101011: begin ctrl = ctrl_t'({7'b0100010, 2'b00, 1'b0}); rt_src = 1'b1; end
      6'b000100: begin ctrl = ctrl_t'({7'b0000001, 2'b01, 1'b0}); rt_src = 1'b1; end
      6'b001000: ctrl = ctrl_t'({7'b0101000, 2'b00, 1'b0});
      6'b001101: begin ctrl = ctrl_t'({7'b0101000, 2'b11, 1'b0}); zext = 1'b1; end
      default:   ctrl.illegal = 1'b1;
    endcase
  end

  // Register read with same-cycle writeback forwarding; r0 is hardwired to zero.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs != '0) rs_data = (wb_we && wb_addr == rs) ? wb_data : rf_q[rs];
    if (rt != '0) rt_data = (wb_we && wb_addr == rt) ? wb_data : rf_q[rt];
  end

  assign stall = instr_valid && !flush && idex_q.valid && idex_q.ctrl.memread &&
                 (idex_q.rt != '0) &&
                 ((idex_q.rt == rs) || (rt_src && idex_q.rt == rt));

  assign bubble = flush || !instr_valid || stall;

  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.valid   = 1'b1;
      idex_d.pc      = pc_in;
      idex_d.rs_data = rs_data;
      idex_d.rt_data = rt_data;
      idex_d.imm     = zext ? {{(XLEN-16){1'b0}}, imm16} : {{(XLEN-16){imm16[15]}}, imm16};
      idex_d.rs      = rs;
      idex_d.rt      = rt;
      idex_d.rd      = rd;
      idex_d.ctrl    = ctrl;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idex_q        <= '0;
      stall_count_q <= '0;
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else begin
      idex_q        <= idex_d;
      stall_count_q <= stall_count_d;
      if (wb_we && wb_addr != '0) rf_q[wb_addr] <= wb_data;
    end
  end

  assign ex_valid    = idex_q.valid;
  assign ex_pc       = idex_q.pc;
  assign ex_rs_data  = idex_q.rs_data;
  assign ex_rt_data  = idex_q.rt_data;
  assign ex_imm      = idex_q.imm;
  assign ex_rs       = idex_q.rs;
  assign ex_rt       = idex_q.rt;
  assign ex_rd       = idex_q.rd;
  assign ex_regdst   = idex_q.ctrl.regdst;
  assign ex_alusrc   = idex_q.ctrl.alusrc;
  assign ex_memtoreg = idex_q.ctrl.memtoreg;
  assign ex_regwrite = idex_q.ctrl.regwrite;
  assign ex_memread  = idex_q.ctrl.memread;
  assign ex_memwrite = idex_q.ctrl.memwrite;
  assign ex_branch   = idex_q.ctrl.branch;
  assign ex_aluop    = idex_q.ctrl.aluop;
  assign ex_illegal  = idex_q.ctrl.illegal;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe; a second instance with CW=2 covers counter saturation.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, instr_in, wb_data;
  logic        instr_valid, flush, wb_we;
  logic [4:0]  wb_addr;

  logic        stall, ex_valid, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite;
  logic        ex_memread, ex_memwrite, ex_branch, ex_illegal;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [1:0]  ex_aluop;
  logic [15:0] stall_count;

  logic        d2_stall, d2_valid, d2_regdst, d2_alusrc, d2_memtoreg, d2_regwrite;
  logic        d2_memread, d2_memwrite, d2_branch, d2_illegal;
  logic [31:0] d2_pc, d2_rs_data, d2_rt_data, d2_imm;
  logic [4:0]  d2_rs, d2_rt, d2_rd;
  logic [1:0]  d2_aluop;
  logic [1:0]  d2_stall_count;

  logic [8:0]  ctl;
  int          n_cmp = 0;
  int          n_err = 0;

  assign ctl = {ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
                ex_branch, ex_aluop};

  always #5 clk = ~clk;

  decode_pipe dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .instr_valid(instr_valid), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_aluop(ex_aluop),
    .ex_illegal(ex_illegal), .stall_count(stall_count)
  );

  decode_pipe #(.CW(2)) dut2 (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .instr_valid(instr_valid), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(d2_stall), .ex_valid(d2_valid), .ex_pc(d2_pc),
    .ex_rs_data(d2_rs_data), .ex_rt_data(d2_rt_data), .ex_imm(d2_imm), .ex_rs(d2_rs),
    .ex_rt(d2_rt), .ex_rd(d2_rd), .ex_regdst(d2_regdst), .ex_alusrc(d2_alusrc),
    .ex_memtoreg(d2_memtoreg), .ex_regwrite(d2_regwrite), .ex_memread(d2_memread),
    .ex_memwrite(d2_memwrite), .ex_branch(d2_branch), .ex_aluop(d2_aluop),
    .ex_illegal(d2_illegal), .stall_count(d2_stall_count)
  );

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d);
    return {6'b000000, s, t, d, 5'd0, 6'h20};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    instr_valid = v;
    instr_in    = ins;
    pc_in       = pc;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; instr_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", ex_valid); end
    n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL rst_cnt got %0d want 0", stall_count); end
    n_cmp++; if (ctl !== 9'd0 || ex_pc !== 32'd0) begin n_err++; $display("FAIL rst_out got ctl=%b pc=%h want 0", ctl, ex_pc); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", stall); end
    reset = 1'b1;
  endtask

  task automatic test_wb_bypass();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    drive(1'b1, itype(6'b100011, 5'd5, 5'd6, 16'd8), 32'h100);
    tick();
    wb_we = 1'b0;
    n_cmp++; if (ex_rs_data !== 32'h1234) begin n_err++; $display("FAIL byp_rs got %h want 1234", ex_rs_data); end
    n_cmp++; if (ex_imm !== 32'd8) begin n_err++; $display("FAIL byp_imm got %h want 8", ex_imm); end
    n_cmp++; if (ex_rt !== 5'd6 || ex_pc !== 32'h100 || ex_valid !== 1'b1) begin n_err++; $display("FAIL byp_fields got rt=%0d pc=%h v=%b want 6 100 1", ex_rt, ex_pc, ex_valid); end
    n_cmp++; if (ctl !== 9'b0111100_00) begin n_err++; $display("FAIL lw_ctl got %b want 011110000", ctl); end
    drive(1'b1, rtype(5'd5, 5'd0, 5'd1), 32'h104);
    tick();
    n_cmp++; if (ex_rs_data !== 32'h1234 || ex_rt_data !== 32'd0) begin n_err++; $display("FAIL rf_read got %h %h want 1234 0", ex_rs_data, ex_rt_data); end
    n_cmp++; if (ctl !== 9'b1001000_10 || ex_rd !== 5'd1) begin n_err++; $display("FAIL r_ctl got %b rd=%0d want 100100010 1", ctl, ex_rd); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, itype(6'b100011, 5'd1, 5'd2, 16'd0), 32'h200);
    tick();
    drive(1'b1, rtype(5'd2, 5'd4, 5'd3), 32'h204);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b want 1", stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0 || ctl !== 9'd0 || ex_pc !== 32'd0) begin n_err++; $display("FAIL lu_bubble got v=%b ctl=%b pc=%h want 0", ex_valid, ctl, ex_pc); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_unstall got %b want 0", stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_rs !== 5'd2 || ex_pc !== 32'h204) begin n_err++; $display("FAIL lu_issue got v=%b rd=%0d rs=%0d pc=%h", ex_valid, ex_rd, ex_rs, ex_pc); end
    n_cmp++; if (stall_count !== 16'd1) begin n_err++; $display("FAIL lu_count got %0d want 1", stall_count); end
  endtask

  task automatic test_rs_only();
    drive(1'b1, itype(6'b100011, 5'd1, 5'd2, 16'd0), 32'h300);
    tick();
    drive(1'b1, itype(6'b001000, 5'd2, 5'd7, 16'd5), 32'h304);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rs_hazard got %b want 1", stall); end
    tick();
    drive(1'b1, itype(6'b100011, 5'd1, 5'd2, 16'd0), 32'h308);
    tick();
    drive(1'b1, itype(6'b001000, 5'd9, 5'd2, 16'd1), 32'h30c);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rt_nosrc got %b want 0", stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rt !== 5'd2 || ctl !== 9'b0101000_00) begin n_err++; $display("FAIL addi_issue got v=%b rt=%0d ctl=%b", ex_valid, ex_rt, ctl); end
  endtask

  task automatic test_imm();
    drive(1'b1, itype(6'b001101, 5'd0, 5'd1, 16'hFFFF), 32'h400);
    tick();
    n_cmp++; if (ex_imm !== 32'h0000FFFF) begin n_err++; $display("FAIL ori_imm got %h want 0000ffff", ex_imm); end
    n_cmp++; if (ctl !== 9'b0101000_11) begin n_err++; $display("FAIL ori_ctl got %b want 010100011", ctl); end
    drive(1'b1, itype(6'b001000, 5'd0, 5'd1, 16'hFFFF), 32'h404);
    tick();
    n_cmp++; if (ex_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_imm got %h want ffffffff", ex_imm); end
    drive(1'b1, itype(6'b101011, 5'd1, 5'd3, 16'hFFFC), 32'h408);
    tick();
    n_cmp++; if (ctl !== 9'b0100010_00 || ex_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL sw got ctl=%b imm=%h", ctl, ex_imm); end
    drive(1'b1, itype(6'b000100, 5'd1, 5'd3, 16'h0010), 32'h40c);
    tick();
    n_cmp++; if (ctl !== 9'b0000001_01 || ex_imm !== 32'h10) begin n_err++; $display("FAIL beq got ctl=%b imm=%h", ctl, ex_imm); end
  endtask

  task automatic test_flush_illegal();
    drive(1'b1, itype(6'b100011, 5'd1, 5'd2, 16'd0), 32'h500);
    tick();
    flush = 1'b1;
    drive(1'b1, rtype(5'd2, 5'd4, 5'd3), 32'h504);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got %b want 0", stall); end
    tick();
    flush = 1'b0;
    n_cmp++; if (ex_valid !== 1'b0 || ex_pc !== 32'd0) begin n_err++; $display("FAIL flush_bubble got v=%b pc=%h want 0", ex_valid, ex_pc); end
    drive(1'b1, itype(6'b111111, 5'd1, 5'd2, 16'h8000), 32'h508);
    tick();
    n_cmp++; if (ex_illegal !== 1'b1 || ex_valid !== 1'b1 || ctl !== 9'd0) begin n_err++; $display("FAIL illegal got ill=%b v=%b ctl=%b", ex_illegal, ex_valid, ctl); end
    drive(1'b0, rtype(5'd1, 5'd2, 5'd3), 32'h50c);
    tick();
    n_cmp++; if (ex_valid !== 1'b0 || ex_illegal !== 1'b0 || ex_pc !== 32'd0) begin n_err++; $display("FAIL invalid got v=%b ill=%b pc=%h", ex_valid, ex_illegal, ex_pc); end
  endtask

  task automatic test_r0();
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    drive(1'b1, rtype(5'd0, 5'd0, 5'd1), 32'h600);
    tick();
    wb_we = 1'b0;
    n_cmp++; if (ex_rs_data !== 32'd0) begin n_err++; $display("FAIL r0_thru got %h want 0", ex_rs_data); end
    drive(1'b1, rtype(5'd0, 5'd0, 5'd1), 32'h604);
    tick();
    n_cmp++; if (ex_rs_data !== 32'd0 || ex_rt_data !== 32'd0) begin n_err++; $display("FAIL r0_read got %h %h want 0", ex_rs_data, ex_rt_data); end
  endtask

  task automatic test_stall_sat();
    do_reset();
    // lw r2,0(r2) back to back: each copy depends on the previous one, stalling every other cycle
    drive(1'b1, itype(6'b100011, 5'd2, 5'd2, 16'd0), 32'h700);
    for (int i = 0; i < 10; i++) tick();
    n_cmp++; if (stall_count !== 16'd5) begin n_err++; $display("FAIL cnt16 got %0d want 5", stall_count); end
    n_cmp++; if (d2_stall_count !== 2'd3) begin n_err++; $display("FAIL cnt2_sat got %0d want 3", d2_stall_count); end
  endtask

  task automatic test_reset_mid();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    drive(1'b1, itype(6'b100011, 5'd5, 5'd6, 16'd4), 32'h800);
    tick();
    reset = 1'b0; wb_addr = 5'd7; wb_data = 32'h77;
    drive(1'b1, rtype(5'd5, 5'd7, 5'd1), 32'h804);
    tick();
    n_cmp++; if (ex_valid !== 1'b0 || ctl !== 9'd0 || ex_pc !== 32'd0 || ex_imm !== 32'd0) begin n_err++; $display("FAIL mid_rst got v=%b ctl=%b pc=%h imm=%h", ex_valid, ctl, ex_pc, ex_imm); end
    n_cmp++; if (stall_count !== 16'd0 || ex_rt !== 5'd0 || ex_rs_data !== 32'd0) begin n_err++; $display("FAIL mid_rst2 got cnt=%0d rt=%0d rs=%h", stall_count, ex_rt, ex_rs_data); end
    reset = 1'b1; wb_we = 1'b0;
    drive(1'b1, rtype(5'd5, 5'd7, 5'd1), 32'h808);
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL post_rst got %b want 0", ex_valid); end
    tick();
    n_cmp++; if (ex_rs_data !== 32'd0 || ex_rt_data !== 32'd0 || ex_valid !== 1'b1) begin n_err++; $display("FAIL rf_cleared got %h %h v=%b want 0 0 1", ex_rs_data, ex_rt_data, ex_valid); end
  endtask

  initial begin
    test_reset();
    test_wb_bypass();
    test_load_use();
    test_rs_only();
    test_imm();
    test_flush_illegal();
    test_r0();
    test_stall_sat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
